// File: rtl/hbm_mvm_pkg.sv
// Shared types for the HBM MVM head scheduler: state encoding and
// address/head-index widths.
package hbm_mvm_pkg;

  localparam int HBM_ADDR_W = 32;
  localparam int HBM_HEAD_W = 8;

  typedef logic [HBM_ADDR_W-1:0] hbm_addr_t;
  typedef logic [HBM_HEAD_W-1:0] head_idx_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    FIN   = 3'd4
  } sched_state_e;

endpackage

// File: rtl/hbm_head_addr_gen.sv
// Base + stride accumulator for one HBM address stream. Load takes
// priority over step; the sum wraps silently at 2^W.
module hbm_head_addr_gen
  import hbm_mvm_pkg::*;
#(
  parameter int W = HBM_ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] base_i,
  input  logic [W-1:0] stride_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] addr_q;
  logic [W-1:0] addr_d;

  // next address: reload from base, advance by stride, or hold
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = base_i;
    end else if (step_i) begin
      addr_d = addr_q + stride_i;
    end
  end

  // accumulator register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign value_o = addr_q;

endmodule

// File: rtl/hbm_mvm_head_scheduler.sv
// Runs the MVM core over all feature heads of one launch. Weight heads
// are shared across groups of cfg_group_size feature heads.
//
// state | meaning
// IDLE  | waiting for start; bad config answered with cfg_err + done
// ISSUE | core_start pulse for the current head
// WAIT  | head in flight; only state that listens to core_done
// NEXT  | advance counters/addresses, decide on another head or finish
// FIN   | done pulse, busy already low
module hbm_mvm_head_scheduler
  import hbm_mvm_pkg::*;
#(
  parameter int ADDR_W = HBM_ADDR_W,
  parameter int HEAD_W = HBM_HEAD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [HEAD_W-1:0] cfg_feature_head,
  input  logic [HEAD_W-1:0] cfg_group_size,
  input  logic [ADDR_W-1:0] cfg_dat_in_base,
  input  logic [ADDR_W-1:0] cfg_dat_in_hstride,
  input  logic [ADDR_W-1:0] cfg_wt_base,
  input  logic [ADDR_W-1:0] cfg_wt_hstride,
  input  logic [ADDR_W-1:0] cfg_dat_out_base,
  input  logic [ADDR_W-1:0] cfg_dat_out_hstride,
  output logic              core_start,
  output logic [ADDR_W-1:0] core_dat_in_addr,
  output logic [ADDR_W-1:0] core_wt_addr,
  output logic [ADDR_W-1:0] core_dat_out_addr,
  output logic [HEAD_W-1:0] core_head_idx,
  input  logic              core_done,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              aborted
);

  localparam logic [HEAD_W-1:0] HEAD_ONE = HEAD_W'(1);

  sched_state_e state_q, state_d;

  logic [HEAD_W-1:0] fh_q, fh_d;
  logic [HEAD_W-1:0] gcnt_q, gcnt_d;
  logic [HEAD_W-1:0] feat_q, feat_d;
  logic [HEAD_W-1:0] grp_q, grp_d;
  logic [ADDR_W-1:0] in_str_q, in_str_d;
  logic [ADDR_W-1:0] wt_str_q, wt_str_d;
  logic [ADDR_W-1:0] out_str_q, out_str_d;
  logic              cfg_err_q, cfg_err_d;
  logic              aborted_q, aborted_d;
  logic              err_done_q, err_done_d;

  logic addr_load;
  logic head_step;
  logic wt_step;
  logic last_head;

  assign last_head = (fh_q == feat_q - HEAD_ONE);

  // next-state, counter and address-control decode
  always_comb begin
    state_d    = state_q;
    fh_d       = fh_q;
    gcnt_d     = gcnt_q;
    feat_d     = feat_q;
    grp_d      = grp_q;
    in_str_d   = in_str_q;
    wt_str_d   = wt_str_q;
    out_str_d  = out_str_q;
    cfg_err_d  = cfg_err_q;
    aborted_d  = aborted_q;
    err_done_d = 1'b0;
    addr_load  = 1'b0;
    head_step  = 1'b0;
    wt_step    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((cfg_feature_head == '0) || (cfg_group_size == '0)) begin
            cfg_err_d  = 1'b1;
            err_done_d = 1'b1;
          end else begin
            cfg_err_d = 1'b0;
            aborted_d = 1'b0;
            feat_d    = cfg_feature_head;
            grp_d     = cfg_group_size;
            in_str_d  = cfg_dat_in_hstride;
            wt_str_d  = cfg_wt_hstride;
            out_str_d = cfg_dat_out_hstride;
            fh_d      = '0;
            gcnt_d    = '0;
            addr_load = 1'b1;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core_done) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        fh_d      = fh_q + HEAD_ONE;
        head_step = 1'b1;
        if (gcnt_q == grp_q - HEAD_ONE) begin
          gcnt_d  = '0;
          wt_step = 1'b1;
        end else begin
          gcnt_d = gcnt_q + HEAD_ONE;
        end
        // abort only takes effect between heads, never mid-head
        if (last_head || abort) begin
          state_d = FIN;
          if (abort && !last_head) begin
            aborted_d = 1'b1;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, counter and latched-config registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fh_q       <= '0;
      gcnt_q     <= '0;
      feat_q     <= '0;
      grp_q      <= '0;
      in_str_q   <= '0;
      wt_str_q   <= '0;
      out_str_q  <= '0;
      cfg_err_q  <= 1'b0;
      aborted_q  <= 1'b0;
      err_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fh_q       <= fh_d;
      gcnt_q     <= gcnt_d;
      feat_q     <= feat_d;
      grp_q      <= grp_d;
      in_str_q   <= in_str_d;
      wt_str_q   <= wt_str_d;
      out_str_q  <= out_str_d;
      cfg_err_q  <= cfg_err_d;
      aborted_q  <= aborted_d;
      err_done_q <= err_done_d;
    end
  end

  hbm_head_addr_gen #(.W(ADDR_W)) u_in_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (addr_load),
    .step_i   (head_step),
    .base_i   (cfg_dat_in_base),
    .stride_i (in_str_q),
    .value_o  (core_dat_in_addr)
  );

  hbm_head_addr_gen #(.W(ADDR_W)) u_wt_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (addr_load),
    .step_i   (wt_step),
    .base_i   (cfg_wt_base),
    .stride_i (wt_str_q),
    .value_o  (core_wt_addr)
  );

  hbm_head_addr_gen #(.W(ADDR_W)) u_out_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (addr_load),
    .step_i   (head_step),
    .base_i   (cfg_dat_out_base),
    .stride_i (out_str_q),
    .value_o  (core_dat_out_addr)
  );

  assign core_start    = (state_q == ISSUE);
  assign busy          = (state_q == ISSUE) || (state_q == WAIT) || (state_q == NEXT);
  assign done          = (state_q == FIN) || err_done_q;
  assign cfg_err       = cfg_err_q;
  assign aborted       = aborted_q;
  assign core_head_idx = fh_q;

endmodule

// File: tb/tb_hbm_mvm_head_scheduler.sv
// Directed bench for the head scheduler with a fixed-latency core model.
module tb_hbm_mvm_head_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_feature_head = '0;
  logic [7:0]  cfg_group_size = '0;
  logic [31:0] cfg_dat_in_base = '0;
  logic [31:0] cfg_dat_in_hstride = '0;
  logic [31:0] cfg_wt_base = '0;
  logic [31:0] cfg_wt_hstride = '0;
  logic [31:0] cfg_dat_out_base = '0;
  logic [31:0] cfg_dat_out_hstride = '0;
  logic        core_start;
  logic [31:0] core_dat_in_addr;
  logic [31:0] core_wt_addr;
  logic [31:0] core_dat_out_addr;
  logic [7:0]  core_head_idx;
  logic        core_done;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        aborted;

  logic resp_done = 1'b0;
  logic spur_done = 1'b0;
  assign core_done = resp_done | spur_done;

  hbm_mvm_head_scheduler dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .abort               (abort),
    .cfg_feature_head    (cfg_feature_head),
    .cfg_group_size      (cfg_group_size),
    .cfg_dat_in_base     (cfg_dat_in_base),
    .cfg_dat_in_hstride  (cfg_dat_in_hstride),
    .cfg_wt_base         (cfg_wt_base),
    .cfg_wt_hstride      (cfg_wt_hstride),
    .cfg_dat_out_base    (cfg_dat_out_base),
    .cfg_dat_out_hstride (cfg_dat_out_hstride),
    .core_start          (core_start),
    .core_dat_in_addr    (core_dat_in_addr),
    .core_wt_addr        (core_wt_addr),
    .core_dat_out_addr   (core_dat_out_addr),
    .core_head_idx       (core_head_idx),
    .core_done           (core_done),
    .busy                (busy),
    .done                (done),
    .cfg_err             (cfg_err),
    .aborted             (aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // observation logs, filled at the falling edge
  int          cs_cnt = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          cd_cnt = 0;
  logic [31:0] in_log  [64];
  logic [31:0] wt_log  [64];
  logic [31:0] out_log [64];
  logic [7:0]  idx_log [64];
  int          cs_cyc  [64];
  int          cd_cyc  [64];
  int          done_cyc = 0;
  logic        done_busy = 1'b0;
  logic        done_prev_busy = 1'b0;
  logic        prev_busy = 1'b0;
  int          resp_cnt = 0;

  // core model (core_done 10 cycles after each core_start) and monitor
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (resp_cnt != 0) begin
      resp_cnt = resp_cnt - 1;
      if (resp_cnt == 0) begin
        resp_done = 1'b1;
        if (cd_cnt < 64) cd_cyc[cd_cnt] = cyc;
        cd_cnt = cd_cnt + 1;
      end
    end
    if (core_start) begin
      resp_cnt = 10;
      if (cs_cnt < 64) begin
        in_log[cs_cnt]  = core_dat_in_addr;
        wt_log[cs_cnt]  = core_wt_addr;
        out_log[cs_cnt] = core_dat_out_addr;
        idx_log[cs_cnt] = core_head_idx;
        cs_cyc[cs_cnt]  = cyc;
      end
      cs_cnt = cs_cnt + 1;
    end
    if (done) begin
      done_cnt       = done_cnt + 1;
      done_cyc       = cyc;
      done_busy      = busy;
      done_prev_busy = prev_busy;
    end
    if (busy) busy_cnt = busy_cnt + 1;
    prev_busy = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] fh, input logic [7:0] grp,
                         input logic [31:0] ib, input logic [31:0] is,
                         input logic [31:0] wb, input logic [31:0] ws,
                         input logic [31:0] ob, input logic [31:0] os);
    cfg_feature_head    = fh;
    cfg_group_size      = grp;
    cfg_dat_in_base     = ib;
    cfg_dat_in_hstride  = is;
    cfg_wt_base         = wb;
    cfg_wt_hstride      = ws;
    cfg_dat_out_base    = ob;
    cfg_dat_out_hstride = os;
  endtask

  // pulse start for one cycle; returns the cycle in which start was high
  task automatic pulse_start(output int t);
    @(negedge clk);
    #1;
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  // bounded wait for the done counter to move past d0
  task automatic wait_done(input int d0, input string tag);
    for (int i = 0; i < 400; i++) begin
      if (done_cnt != d0) break;
      tick(1);
    end
    check(tag, done_cnt, d0 + 1);
  endtask

  int t0, c0, d0, b0;

  initial begin
    // reset
    tick(3);
    check("rst core_start", core_start, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst cfg_err", cfg_err, 0);
    check("rst aborted", aborted, 0);
    check("rst in_addr", core_dat_in_addr, 0);
    check("rst wt_addr", core_wt_addr, 0);
    check("rst out_addr", core_dat_out_addr, 0);
    check("rst head_idx", core_head_idx, 0);
    rst_n = 1'b1;
    tick(2);

    // grouped-query run: 4 feature heads, 2 per weight head
    set_cfg(8'd4, 8'd2, 32'h0, 32'h1000, 32'h0200_0000, 32'h800, 32'h0800_0000, 32'h1000);
    c0 = cs_cnt; d0 = done_cnt;
    pulse_start(t0);
    wait_done(d0, "gqa done count");
    tick(2);
    check("gqa core_start count", cs_cnt - c0, 4);
    check("gqa wt0", wt_log[c0+0], 32'h0200_0000);
    check("gqa wt1", wt_log[c0+1], 32'h0200_0000);
    check("gqa wt2", wt_log[c0+2], 32'h0200_0800);
    check("gqa wt3", wt_log[c0+3], 32'h0200_0800);
    check("gqa in3", in_log[c0+3], 32'h0000_3000);
    check("gqa out0", out_log[c0+0], 32'h0800_0000);
    check("gqa out3", out_log[c0+3], 32'h0800_3000);
    check("gqa idx3", idx_log[c0+3], 3);
    check("gqa single done", done_cnt - d0, 1);
    check("gqa cfg_err", cfg_err, 0);
    check("gqa aborted", aborted, 0);
    check("lat start->core_start", cs_cyc[c0], t0 + 1);
    check("lat core_done->core_start", cs_cyc[c0+1], cd_cyc[c0] + 2);
    check("lat head spacing", cs_cyc[c0+2] - cs_cyc[c0+1], 12);
    check("busy low at done", done_busy, 0);
    check("busy high before done", done_prev_busy, 1);
    check("done after last core_done", done_cyc, cd_cyc[c0+3] + 2);

    // config errors
    set_cfg(8'd0, 8'd2, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h0);
    c0 = cs_cnt; d0 = done_cnt; b0 = busy_cnt;
    pulse_start(t0);
    tick(3);
    check("cfgerr fh0 flag", cfg_err, 1);
    check("cfgerr fh0 done cnt", done_cnt - d0, 1);
    check("cfgerr fh0 done cycle", done_cyc, t0 + 1);
    set_cfg(8'd3, 8'd0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h0);
    d0 = done_cnt;
    pulse_start(t0);
    tick(3);
    check("cfgerr grp0 flag", cfg_err, 1);
    check("cfgerr grp0 done cycle", done_cyc, t0 + 1);
    check("cfgerr no core_start", cs_cnt - c0, 0);
    check("cfgerr busy never", busy_cnt - b0, 0);
    set_cfg(8'd1, 8'd1, 32'h40, 32'h1000, 32'h80, 32'h0, 32'hC0, 32'h0);
    d0 = done_cnt;
    pulse_start(t0);
    check("cfgerr cleared by valid start", cfg_err, 0);
    wait_done(d0, "valid-after-err done");
    tick(2);

    // abort raised during head 1
    set_cfg(8'd4, 8'd1, 32'h0, 32'h100, 32'h0, 32'h100, 32'h0, 32'h100);
    c0 = cs_cnt; d0 = done_cnt;
    pulse_start(t0);
    for (int i = 0; i < 100; i++) begin
      if (cs_cnt - c0 >= 2) break;
      tick(1);
    end
    tick(3);
    abort = 1'b1;
    wait_done(d0, "abort done count");
    abort = 1'b0;
    tick(2);
    check("abort core_start count", cs_cnt - c0, 2);
    check("abort flag", aborted, 1);
    check("abort head1 completed", cd_cnt - c0, 2);

    // abort in idle is ignored
    abort = 1'b1;
    tick(3);
    check("abort idle busy", busy, 0);
    abort = 1'b0;

    // robustness: spurious core_done in IDLE and ISSUE, start while busy
    spur_done = 1'b1;
    tick(1);
    spur_done = 1'b0;
    set_cfg(8'd2, 8'd1, 32'h500, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0);
    c0 = cs_cnt; d0 = done_cnt;
    pulse_start(t0);
    check("robust aborted cleared", aborted, 0);
    spur_done = 1'b1;
    tick(1);
    spur_done = 1'b0;
    tick(2);
    set_cfg(8'd5, 8'd1, 32'h9000, 32'h20, 32'h0, 32'h0, 32'h0, 32'h0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(d0, "robust done count");
    tick(2);
    check("robust core_start count", cs_cnt - c0, 2);
    check("robust spacing", cs_cyc[c0+1] - cs_cyc[c0], 12);
    check("robust in1", in_log[c0+1], 32'h510);

    // reset in the middle of a head
    set_cfg(8'd4, 8'd1, 32'h100, 32'h100, 32'h200, 32'h100, 32'h300, 32'h100);
    c0 = cs_cnt; d0 = done_cnt;
    pulse_start(t0);
    tick(4);
    rst_n = 1'b0;
    tick(1);
    check("midrst busy", busy, 0);
    check("midrst core_start", core_start, 0);
    check("midrst in_addr", core_dat_in_addr, 0);
    check("midrst out_addr", core_dat_out_addr, 0);
    check("midrst head_idx", core_head_idx, 0);
    rst_n = 1'b1;
    tick(20);
    check("midrst no done", done_cnt - d0, 0);

    // address wrap and partial final group
    set_cfg(8'd3, 8'd2, 32'hFFFF_F000, 32'h1000, 32'h100, 32'h40, 32'h0, 32'h8);
    c0 = cs_cnt; d0 = done_cnt;
    pulse_start(t0);
    wait_done(d0, "wrap done count");
    tick(2);
    check("wrap core_start count", cs_cnt - c0, 3);
    check("wrap in0", in_log[c0+0], 32'hFFFF_F000);
    check("wrap in1", in_log[c0+1], 32'h0000_0000);
    check("wrap in2", in_log[c0+2], 32'h0000_1000);
    check("wrap wt2", wt_log[c0+2], 32'h140);
    check("wrap wt final", core_wt_addr, 32'h140);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
